// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Results are computed at accept
// time, held in pending registers, and committed after a fixed busy window.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          dz_q, dz_d;

  logic [63:0] mul_s, mul_u;
  logic [31:0] a_mag, b_mag, bu_safe, bm_safe;
  logic [31:0] uq, ur, mq, mr, sq, sr;

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign mul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign mul_u = {32'b0, A} * {32'b0, B};

  // Signed divide via magnitudes; 0x80000000/-1 wraps back to 0x80000000, rem 0.
  assign a_mag   = A[31] ? -A : A;
  assign b_mag   = B[31] ? -B : B;
  assign bu_safe = (B == 32'd0) ? 32'd1 : B;
  assign bm_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq      = A / bu_safe;
  assign ur      = A % bu_safe;
  assign mq      = a_mag / bm_safe;
  assign mr      = a_mag % bm_safe;
  assign sq      = (A[31] ^ B[31]) ? -mq : mq;
  assign sr      = A[31] ? -mr : mr;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    dz_d   = dz_q;
    if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
        if (!dz_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end
    end else if (Start) begin
      case (op_e'(Op))
        OP_MULT: begin
          {phi_d, plo_d} = mul_s;
          dz_d   = 1'b0;
          busy_d = 1'b1;
          cnt_d  = CW'(MULT_CYCLES - 1);
        end
        OP_MULTU: begin
          {phi_d, plo_d} = mul_u;
          dz_d   = 1'b0;
          busy_d = 1'b1;
          cnt_d  = CW'(MULT_CYCLES - 1);
        end
        OP_DIV: begin
          phi_d  = sr;
          plo_d  = sq;
          dz_d   = (B == 32'd0);
          busy_d = 1'b1;
          cnt_d  = CW'(DIV_CYCLES - 1);
        end
        OP_DIVU: begin
          phi_d  = ur;
          plo_d  = uq;
          dz_d   = (B == 32'd0);
          busy_d = 1'b1;
          cnt_d  = CW'(DIV_CYCLES - 1);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      dz_q   <= dz_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: cycle-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        Reset, Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo} using plain integer arithmetic.
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int              sa, sb, q, r;
    longint          sp;
    longint unsigned up;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sb); return {1'b0, 64'(sp)}; end
      3'd1: begin up = 64'(a) * 64'(b); return {1'b0, up}; end
      3'd2: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        return {1'b0, a % b, a / b};
      end
      default: return 65'd0;
    endcase
  endfunction

  // Model: a pending result commits at the edge N cycles after acceptance.
  logic [31:0] m_hi = '0, m_lo = '0;
  bit          m_pend = 1'b0, m_dz = 1'b0;
  logic [63:0] m_res = '0;
  longint      m_cyc = 0, m_commit = 0;

  always @(posedge clk) begin
    if (Reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= 1'b0;
    end else if (m_pend) begin
      if (m_cyc + 1 == m_commit) begin
        if (!m_dz) begin
          m_hi <= m_res[63:32];
          m_lo <= m_res[31:0];
        end
        m_pend <= 1'b0;
      end
    end else if (Start) begin
      case (Op)
        3'd4: m_hi <= A;
        3'd5: m_lo <= A;
        3'd0, 3'd1, 3'd2, 3'd3: begin
          {m_dz, m_res} <= ref_op(Op, A, B);
          m_pend   <= 1'b1;
          m_commit <= m_cyc + 1 + ((Op < 3'd2) ? 5 : 10);
        end
        default: ;
      endcase
    end
    m_cyc <= m_cyc + 1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", {31'd0, Busy}, {31'd0, m_pend});
      chk("model_hi", HI, m_hi);
      chk("model_lo", LO, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (Busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int n;

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    cmp_en = 1'b1;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    repeat (20) @(negedge clk);
    chk("idle_hi", HI, 32'd0);
    chk("idle_lo", LO, 32'd0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    busy_len(n);
    chk("mult_len", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    busy_len(n);
    chk("multu_len", n, 32'd5);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    busy_len(n);
    chk("div_len", n, 32'd10);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    chk("div_lo", LO, 32'hFFFF_FFFD);

    issue(3'd3, 32'd7, 32'd2);
    busy_len(n);
    chk("divu_hi", HI, 32'd1);
    chk("divu_lo", LO, 32'd3);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len(n);
    chk("divovf_hi", HI, 32'd0);
    chk("divovf_lo", LO, 32'h8000_0000);

    issue(3'd4, 32'h1234, 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    issue(3'd3, 32'd100, 32'd0);
    busy_len(n);
    chk("dz_len", n, 32'd10);
    chk("dz_hi", HI, 32'h1234);
    chk("dz_lo", LO, 32'h5678);

    // Requests during the busy window must be dropped.
    issue(3'd0, 32'd5, 32'd7);
    Start = 1'b1; Op = 3'd5; A = 32'hAAAA;
    @(negedge clk);
    Op = 3'd0; A = 32'd3; B = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    busy_len(n);
    chk("ign_len", n, 32'd3);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd35);
    repeat (10) @(negedge clk);
    chk("ign_nobusy", {31'd0, Busy}, 32'd0);
    chk("ign_lo_hold", LO, 32'd35);

    issue(3'd2, 32'd50, 32'd5);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("rstmid_busy", {31'd0, Busy}, 32'd0);
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    repeat (15) @(negedge clk);
    chk("rstmid_hi_late", HI, 32'd0);
    chk("rstmid_lo_late", LO, 32'd0);

    repeat (600) begin
      @(negedge clk);
      Reset = ($urandom_range(0, 79) == 0);
      Start = ($urandom_range(0, 2) != 0);
      Op    = 3'($urandom_range(0, 7));
      A     = pick();
      B     = pick();
    end
    @(negedge clk);
    Reset = 1'b0; Start = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
